// File: rtl/hi_lo_muldiv_if.sv
// Bus bundle for the HI/LO register pair and its multiply/divide engine.
// The execute stage drives through the master modport; the HI/LO block
// receives through the slave modport. WIDTH must match the attached block.
interface hi_lo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             HI_LO_ena;
  logic             op_start;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] HI_in;
  logic [WIDTH-1:0] LO_in;
  logic             HI_w;
  logic             LO_w;
  logic [WIDTH-1:0] HI_out;
  logic [WIDTH-1:0] LO_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output HI_LO_ena, op_start, op_sel, op_a, op_b, HI_in, LO_in, HI_w, LO_w,
    input  HI_out, LO_out, busy, done, div_zero
  );

  modport slave (
    input  HI_LO_ena, op_start, op_sel, op_a, op_b, HI_in, LO_in, HI_w, LO_w,
    output HI_out, LO_out, busy, done, div_zero
  );
endinterface

// File: rtl/hi_lo_muldiv.sv
// HI/LO register pair with an iterative radix-2 multiply/divide engine.
// Signed operations run on magnitudes; the sign fix is applied in a single
// SIGN cycle that also commits HI and LO together.
module hi_lo_muldiv #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic          HI_LO_clk,
  input  logic          HI_LO_rst,
  hi_lo_muldiv_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         op_r;
  logic               sign_a_r, sign_b_r, dz_r;
  logic [WIDTH-1:0]   a_raw_r;
  logic [WIDTH-1:0]   opnd_r;      // multiplicand (mul) or divisor magnitude (div)
  logic [2*WIDTH-1:0] acc_r;       // {partial product, multiplier} or {remainder, quotient}
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r, div_zero_r;

  logic               start_s, step_s, commit_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_trial_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;

  // Operand magnitudes for the signed variants (op_sel[0] marks signed).
  always_comb begin
    a_mag_s = bus.op_a;
    b_mag_s = bus.op_b;
    if (bus.op_sel[0] && bus.op_a[WIDTH-1]) begin
      a_mag_s = {WIDTH{1'b0}} - bus.op_a;
    end else begin
      a_mag_s = bus.op_a;
    end
    if (bus.op_sel[0] && bus.op_b[WIDTH-1]) begin
      b_mag_s = {WIDTH{1'b0}} - bus.op_b;
    end else begin
      b_mag_s = bus.op_b;
    end
  end

  // FSM state register.
  always_ff @(posedge HI_LO_clk) begin
    if (HI_LO_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and control strobes; disabled cycles hold everything.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    step_s      = 1'b0;
    commit_s    = 1'b0;
    if (bus.HI_LO_ena) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.op_start) begin
            state_nxt_s = ST_CALC;
            start_s     = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CALC: begin
          step_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_SIGN;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end
        ST_SIGN: begin
          commit_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    div_trial_s = div_shift_s - {1'b0, opnd_r};
    if (!op_r[1]) begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else if (!div_trial_s[WIDTH]) begin
      acc_step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix and divide-by-zero substitution for the committed result.
  always_comb begin
    res_hi_s = hi_r;
    res_lo_s = lo_r;
    case (op_r)
      2'b00: {res_hi_s, res_lo_s} = acc_r;
      2'b01: begin
        if (sign_a_r ^ sign_b_r) begin
          {res_hi_s, res_lo_s} = {(2*WIDTH){1'b0}} - acc_r;
        end else begin
          {res_hi_s, res_lo_s} = acc_r;
        end
      end
      2'b10, 2'b11: begin
        if (dz_r) begin
          res_hi_s = a_raw_r;
          res_lo_s = {WIDTH{1'b1}};
        end else begin
          // Quotient truncates toward zero; remainder follows the dividend.
          if (sign_a_r ^ sign_b_r) begin
            res_lo_s = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
          end else begin
            res_lo_s = acc_r[WIDTH-1:0];
          end
          if (sign_a_r) begin
            res_hi_s = {WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH];
          end else begin
            res_hi_s = acc_r[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: begin
        res_hi_s = hi_r;
        res_lo_s = lo_r;
      end
    endcase
  end

  // Engine datapath: operand capture at start, then one step per CALC cycle.
  always_ff @(posedge HI_LO_clk) begin
    if (HI_LO_rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= 2'b00;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      dz_r     <= 1'b0;
      a_raw_r  <= {WIDTH{1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
    end else if (start_s) begin
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= bus.op_sel;
      sign_a_r <= bus.op_sel[0] & bus.op_a[WIDTH-1];
      sign_b_r <= bus.op_sel[0] & bus.op_b[WIDTH-1];
      dz_r     <= bus.op_sel[1] & (bus.op_b == {WIDTH{1'b0}});
      a_raw_r  <= bus.op_a;
      opnd_r   <= bus.op_sel[1] ? b_mag_s : a_mag_s;
      acc_r    <= {{WIDTH{1'b0}}, (bus.op_sel[1] ? a_mag_s : b_mag_s)};
    end else if (step_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      acc_r <= acc_step_s;
    end
  end

  // HI/LO registers: engine commit beats a same-cycle direct write.
  always_ff @(posedge HI_LO_clk) begin
    if (HI_LO_rst) begin
      hi_r <= RESET_VAL;
      lo_r <= RESET_VAL;
    end else if (bus.HI_LO_ena) begin
      if (commit_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else begin
        if (bus.HI_w) hi_r <= bus.HI_in;
        if (bus.LO_w) lo_r <= bus.LO_in;
      end
    end
  end

  // Status flags; done/div_zero pulse for the cycle after commit.
  always_ff @(posedge HI_LO_clk) begin
    if (HI_LO_rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= commit_s;
      div_zero_r <= commit_s & dz_r;
    end
  end

  assign bus.HI_out   = hi_r;
  assign bus.LO_out   = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r & bus.HI_LO_ena;
  assign bus.div_zero = div_zero_r & bus.HI_LO_ena;
endmodule

// File: tb/tb_hi_lo_muldiv.sv
// Scoreboard bench for hi_lo_muldiv: expected results are queued at issue
// and compared when done pulses.
module tb_hi_lo_muldiv;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hi_lo_muldiv_if #(.WIDTH(32)) bus ();

  hi_lo_muldiv #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .HI_LO_clk (clk),
    .HI_LO_rst (rst),
    .bus       (bus)
  );

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb, q, r;
    e  = '{dz: 1'b0, hi: 32'h0, lo: 32'h0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (sel)
      2'b00: begin
        p = {32'h0, a} * {32'h0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        q = sa * sb;
        e.hi = q[63:32];
        e.lo = q[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          e.dz = 1'b1;
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
        end else if (sel == 2'b10) begin
          e.lo = a / b;
          e.hi = a % b;
        end else begin
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Issue one operation, optionally freezing, writing HI mid-flight or
  // re-requesting a start while busy, and compare against the scoreboard.
  task automatic run_op(input string tag, input logic [1:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input int freeze_at, input int hiw_at,
                        input int restart_at);
    exp_t e;
    int   busy_cnt = 0;
    bit   got_done = 1'b0;
    int   exp_busy;
    sb_q.push_back(model(sel, a, b));
    exp_busy     = (freeze_at >= 0) ? 38 : 33;
    bus.op_sel   = sel;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_start = 1'b1;
    for (int c = 0; c < 100 && !got_done; c++) begin
      @(negedge clk);
      bus.op_start = 1'b0;
      if (bus.done) begin
        got_done = 1'b1;
        e = sb_q.pop_front();
        check_val({tag, " hi"}, 64'(bus.HI_out), 64'(e.hi));
        check_val({tag, " lo"}, 64'(bus.LO_out), 64'(e.lo));
        check_val({tag, " div_zero"}, 64'(bus.div_zero), 64'(e.dz));
        check_val({tag, " busy at done"}, 64'(bus.busy), 64'd0);
      end else begin
        if (bus.busy) busy_cnt++;
        if (hiw_at >= 0 && c == hiw_at + 1)
          check_val({tag, " direct hi"}, 64'(bus.HI_out), 64'h0000_00AA);
      end
      bus.HI_w      = (c == hiw_at);
      bus.HI_in     = 32'h0000_00AA;
      bus.HI_LO_ena = !(freeze_at >= 0 && c >= freeze_at && c < freeze_at + 5);
      if (c == restart_at) begin
        bus.op_start = 1'b1;
        bus.op_sel   = 2'b00;
        bus.op_a     = 32'h0000_0005;
        bus.op_b     = 32'h0000_0003;
      end
    end
    bus.HI_w      = 1'b0;
    bus.op_start  = 1'b0;
    bus.HI_LO_ena = 1'b1;
    check_val({tag, " done seen"}, 64'(got_done), 64'd1);
    if (!got_done) void'(sb_q.pop_front());
    check_val({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
    @(negedge clk);
    check_val({tag, " done pulse width"}, 64'(bus.done), 64'd0);
    check_val({tag, " idle after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int done_cnt;
    logic [1:0]  rs;
    logic [31:0] ra, rb;

    rst           = 1'b1;
    bus.HI_LO_ena = 1'b1;
    bus.op_start  = 1'b0;
    bus.op_sel    = 2'b00;
    bus.op_a      = 32'h0;
    bus.op_b      = 32'h0;
    bus.HI_in     = 32'h0;
    bus.LO_in     = 32'h0;
    bus.HI_w      = 1'b0;
    bus.LO_w      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("reset hi", 64'(bus.HI_out), 64'd0);
    check_val("reset lo", 64'(bus.LO_out), 64'd0);
    check_val("reset busy", 64'(bus.busy), 64'd0);
    check_val("reset done", 64'(bus.done), 64'd0);

    // Direct writes in IDLE.
    bus.HI_w = 1'b1; bus.HI_in = 32'h1234_5678;
    bus.LO_w = 1'b1; bus.LO_in = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.HI_w = 1'b0; bus.LO_w = 1'b0;
    check_val("direct hi", 64'(bus.HI_out), 64'h1234_5678);
    check_val("direct lo", 64'(bus.LO_out), 64'h9ABC_DEF0);

    run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    run_op("mult -3*5", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, -1, -1, -1);
    run_op("mult min*min", 2'b01, 32'h8000_0000, 32'h8000_0000, -1, -1, -1);
    run_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1, -1);
    run_op("div 7/-2", 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, -1, -1, -1);
    run_op("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    run_op("divu 7/0", 2'b10, 32'h0000_0007, 32'h0000_0000, -1, -1, -1);
    run_op("div -100/0", 2'b11, 32'hFFFF_FF9C, 32'h0000_0000, -1, -1, -1);
    run_op("divu 100/7", 2'b10, 32'h0000_0064, 32'h0000_0007, -1, -1, -1);
    run_op("hi_w mid-op", 2'b00, 32'h0001_0000, 32'h0003_0000, -1, 5, -1);
    run_op("hi_w at commit", 2'b00, 32'h0001_0000, 32'h0003_0000, -1, 32, -1);
    run_op("start while busy", 2'b10, 32'h0000_03E8, 32'h0000_0021, -1, -1, 10);
    run_op("ena freeze", 2'b01, 32'hFFFF_FF85, 32'h0000_1234, 8, -1, -1);

    // Reset in the middle of CALC abandons the operation.
    bus.op_sel = 2'b00; bus.op_a = 32'h0000_0009; bus.op_b = 32'h0000_0009;
    bus.op_start = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid rst hi", 64'(bus.HI_out), 64'd0);
    check_val("mid rst lo", 64'(bus.LO_out), 64'd0);
    check_val("mid rst busy", 64'(bus.busy), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check_val("mid rst no done", 64'(done_cnt), 64'd0);

    // Random mix of operations.
    for (int i = 0; i < 24; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0)      rb = 32'h0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else                                rb = 32'($urandom_range(1, 20));
      run_op($sformatf("rand%0d", i), rs, ra, rb, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
